// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester port of the data-memory arbiter
//
// Purpose: bundles the beat request, beat acceptance and beat response of one
//          master so the arbiter and its clients share a single port type.
// Signals:
//   req     master -> arbiter  beat request, fields held until gnt
//   we      master -> arbiter  1 = write beat, 0 = read beat
//   addr    master -> arbiter  byte address (must be word aligned)
//   wdata   master -> arbiter  write data
//   lock    master -> arbiter  keep ownership after this beat
//   gnt     arbiter -> master  combinational; beat accepted when req & gnt
//   rvalid  arbiter -> master  one-cycle response pulse, cycle after acceptance
//   rdata   arbiter -> master  read data (0 for writes and errored beats)
//   rerr    arbiter -> master  misaligned / out-of-range beat, valid with rvalid

interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid, rdata, rerr
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid, rdata, rerr
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin / burst-lock arbiter for DataMemory
//
// Purpose: shares one single-port DataMemory (DEPTH x 32-bit, async read,
//          write on posedge) between the CPU path (m0) and the DMA/debug path
//          (m1). One beat per cycle, round-robin between simultaneous
//          requesters, optional burst lock capped at MAX_LOCK beats, per-beat
//          address checking and a registered response one cycle later.
// Ports:
//   clk      in   single clock
//   reset_n  in   synchronous active-low reset
//   m0, m1   slave modport of dmem_arbiter_if (request / grant / response)
//   mem_we   out  DataMemory write enable
//   mem_a    out  DataMemory byte address (granted port, 0 when idle)
//   mem_wd   out  DataMemory write data (granted port, 0 when idle)
//   mem_rd   in   DataMemory read data (combinational from mem_a)

module dmem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int MAX_LOCK = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    dmem_arbiter_if.slave   m0,
    dmem_arbiter_if.slave   m1,
    output logic            mem_we,
    output logic [31:0]     mem_a,
    output logic [31:0]     mem_wd,
    input  logic [31:0]     mem_rd
);

    localparam int          CW         = $clog2(MAX_LOCK + 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;          // 0 favours m0, 1 favours m1
    logic [CW-1:0]   cnt_q, cnt_d;        // beats taken by the current lock owner
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic            rerr0_q, rerr0_d;
    logic            rerr1_q, rerr1_d;
    logic [31:0]     rdata0_q, rdata0_d;
    logic [31:0]     rdata1_q, rdata1_d;

    logic            gnt0;
    logic            gnt1;
    logic            any_gnt;
    logic            sel;                 // index of the granted port
    logic            sel_we;
    logic            sel_lock;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic            sel_err;
    logic [31:0]     beat_rdata;
    logic [CW-1:0]   beat_cnt;
    logic            owner1;

    // Grant selection and memory-side drive.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    gnt0 = m0.req & (~m1.req | ~rr_q);
                    gnt1 = m1.req & (~m0.req |  rr_q);
                end
                OWN0:    gnt0 = m0.req;
                OWN1:    gnt1 = m1.req;
                default: ;
            endcase
        end

        any_gnt   = gnt0 | gnt1;
        sel       = gnt1;
        sel_we    = sel ? m1.we    : m0.we;
        sel_lock  = sel ? m1.lock  : m0.lock;
        sel_addr  = sel ? m1.addr  : m0.addr;
        sel_wdata = sel ? m1.wdata : m0.wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);

        mem_we = any_gnt & sel_we & ~sel_err;
        mem_a  = any_gnt ? sel_addr  : 32'd0;
        mem_wd = any_gnt ? sel_wdata : 32'd0;
    end

    // Next state: ownership, round-robin pointer, burst count, responses.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = '0;
        owner1   = (state_q == OWN1);
        beat_cnt = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);

        if (state_q == IDLE) begin
            if (m0.req && m1.req) begin
                rr_d = ~rr_q;
            end
            if (any_gnt && sel_lock) begin
                if (beat_cnt >= CW'(MAX_LOCK)) begin
                    rr_d = ~sel;
                end else begin
                    state_d = sel ? OWN1 : OWN0;
                    cnt_d   = beat_cnt;
                end
            end
        end else begin
            if (any_gnt && sel_lock && (beat_cnt < CW'(MAX_LOCK))) begin
                cnt_d = beat_cnt;
            end else begin
                // Every lock release hands priority to the other port so a
                // master that keeps ending bursts cleanly cannot re-lock
                // ahead of a waiting requester.
                state_d = IDLE;
                rr_d    = ~owner1;
            end
        end

        beat_rdata = (any_gnt && !sel_we && !sel_err) ? mem_rd : 32'd0;
        rvalid0_d  = gnt0;
        rvalid1_d  = gnt1;
        rerr0_d    = gnt0 & sel_err;
        rerr1_d    = gnt1 & sel_err;
        rdata0_d   = gnt0 ? beat_rdata : 32'd0;
        rdata1_d   = gnt1 ? beat_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rerr0_q   <= 1'b0;
            rerr1_q   <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rerr0_q   <= rerr0_d;
            rerr1_q   <= rerr1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    // A response still in flight when reset is asserted is discarded at once.
    assign m0.rvalid = rvalid0_q & reset_n;
    assign m1.rvalid = rvalid1_q & reset_n;
    assign m0.rerr   = rerr0_q & reset_n;
    assign m1.rerr   = rerr1_q & reset_n;
    assign m0.rdata  = reset_n ? rdata0_q : 32'd0;
    assign m1.rdata  = reset_n ? rdata1_q : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    localparam int DEPTH    = 64;
    localparam int MAX_LOCK = 8;

    typedef logic [31:0] word_arr_t [DEPTH];

    typedef struct {
        logic        req;
        logic        we;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    function automatic word_arr_t init_ram();
        word_arr_t a;
        for (int i = 0; i < DEPTH; i++) a[i] = (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
        return a;
    endfunction

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    dmem_arbiter_if m0_if ();
    dmem_arbiter_if m1_if ();

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .mem_we  (mem_we),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    // DataMemory: async read, write on posedge.
    word_arr_t ram = init_ram();
    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk) if (mem_we) ram[mem_a[7:2]] <= mem_wd;

    // Reference model state.
    word_arr_t   ref_mem;
    int          owner;
    int          beats;
    int          favour;
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];
    logic        exp_re [2];
    int          wait_cyc [2];
    logic        acc [2];
    logic        last_g [2];
    logic        last_rv [2];
    logic        we_seen;

    int vectors;
    int miscompares;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur(int p);
        beat_t b;
        if (p == 0) begin
            b.req = m0_if.req; b.we = m0_if.we; b.lock = m0_if.lock;
            b.addr = m0_if.addr; b.wdata = m0_if.wdata;
        end else begin
            b.req = m1_if.req; b.we = m1_if.we; b.lock = m1_if.lock;
            b.addr = m1_if.addr; b.wdata = m1_if.wdata;
        end
        return b;
    endfunction

    function automatic logic bad_addr(logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    // Which port the rules say owns this cycle's slot (-1 = none).
    function automatic int model_win();
        beat_t b0 = cur(0);
        beat_t b1 = cur(1);
        if (!reset_n) return -1;
        if (owner < 0) begin
            if (b0.req && b1.req) return favour;
            if (b0.req) return 0;
            if (b1.req) return 1;
            return -1;
        end
        return cur(owner).req ? owner : -1;
    endfunction

    task automatic drive(int p, logic req, logic we, logic [31:0] addr, logic [31:0] wdata, logic lock);
        if (p == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.lock = lock;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.lock = lock;
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        int          w;
        beat_t       b [2];
        logic        ewe;
        logic [31:0] ea;
        logic [31:0] ewd;
        logic        rv_now;
        @(negedge clk);
        b[0] = cur(0);
        b[1] = cur(1);
        w    = model_win();
        ewe = 1'b0; ea = 32'd0; ewd = 32'd0;
        if (w >= 0) begin
            ewe = b[w].we && !bad_addr(b[w].addr);
            ea  = b[w].addr;
            ewd = b[w].wdata;
        end
        last_g[0]  = m0_if.gnt;
        last_g[1]  = m1_if.gnt;
        last_rv[0] = m0_if.rvalid;
        last_rv[1] = m1_if.rvalid;
        we_seen    = we_seen | mem_we;
        chk("gnt0", m0_if.gnt, w == 0);
        chk("gnt1", m1_if.gnt, w == 1);
        chk("mem_we", mem_we, ewe);
        chk("mem_a", mem_a, ea);
        chk("mem_wd", mem_wd, ewd);
        rv_now = reset_n && exp_rv[0];
        chk("rvalid0", m0_if.rvalid, rv_now);
        if (rv_now) begin
            chk("rdata0", m0_if.rdata, exp_rd[0]);
            chk("rerr0", m0_if.rerr, exp_re[0]);
        end
        rv_now = reset_n && exp_rv[1];
        chk("rvalid1", m1_if.rvalid, rv_now);
        if (rv_now) begin
            chk("rdata1", m1_if.rdata, exp_rd[1]);
            chk("rerr1", m1_if.rerr, exp_re[1]);
        end

        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            exp_rv[p] = 1'b0; exp_rd[p] = 32'd0; exp_re[p] = 1'b0; acc[p] = 1'b0;
        end
        if (!reset_n) begin
            owner = -1; beats = 0; favour = 0;
            wait_cyc[0] = 0; wait_cyc[1] = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (b[p].req && w != p) wait_cyc[p]++;
                else if (!b[p].req) wait_cyc[p] = 0;
            end
            if (w >= 0) begin
                chk("fair_wait", wait_cyc[w] <= MAX_LOCK + 1, 1'b1);
                wait_cyc[w] = 0;
                acc[w]      = 1'b1;
                exp_rv[w]   = 1'b1;
                exp_re[w]   = bad_addr(b[w].addr);
                if (!exp_re[w] && !b[w].we) exp_rd[w] = ref_mem[b[w].addr[7:2]];
                if (!exp_re[w] && b[w].we) ref_mem[b[w].addr[7:2]] = b[w].wdata;
            end
            if (owner < 0) begin
                if (b[0].req && b[1].req) favour = 1 - favour;
                if (w >= 0 && b[w].lock) begin
                    if (MAX_LOCK == 1) favour = 1 - w;
                    else begin owner = w; beats = 1; end
                end
            end else if (w == owner) begin
                beats++;
                if (!b[w].lock || beats == MAX_LOCK) begin
                    favour = 1 - owner; owner = -1; beats = 0;
                end
            end else begin
                favour = 1 - owner; owner = -1; beats = 0;
            end
        end
        #1;
    endtask

    int          order [$];
    int          k;
    logic [31:0] r0;
    logic        pend [2];
    beat_t       nb;
    int          sel;

    initial begin
        vectors = 0; miscompares = 0;
        ref_mem = init_ram();
        owner = -1; beats = 0; favour = 0; we_seen = 1'b0;
        for (int p = 0; p < 2; p++) begin
            exp_rv[p] = 1'b0; exp_rd[p] = 32'd0; exp_re[p] = 1'b0;
            wait_cyc[p] = 0; acc[p] = 1'b0; pend[p] = 1'b0;
            drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        end

        // Reset.
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_rvalid0", m0_if.rvalid, 1'b0);
        chk("rst_rvalid1", m1_if.rvalid, 1'b0);
        chk("rst_rdata0", m0_if.rdata, 32'd0);
        chk("rst_gnt0", m0_if.gnt, 1'b0);

        // Write then read-back on m0.
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        tick();
        chk("wr_rvalid", m0_if.rvalid, 1'b1);
        chk("wr_rdata", m0_if.rdata, 32'd0);
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
        tick();
        chk("rd_rvalid", m0_if.rvalid, 1'b1);
        chk("rd_rdata", m0_if.rdata, 32'hDEADBEEF);
        chk("rd_rerr", m0_if.rerr, 1'b0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();

        // Both reading every cycle without lock: strict alternation.
        drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h14, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("alt_g0", last_g[0], (i % 2) == 0);
            chk("alt_rv1", m1_if.rvalid, (i % 2) == 1);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();

        // m1 locked burst of 12 writes while m0 keeps requesting.
        k = 0;
        drive(1, 1'b1, 1'b1, 32'h40, 32'h1000, 1'b1);
        for (int cyc = 0; cyc < 40 && k < 12; cyc++) begin
            tick();
            if (cyc == 0) drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
            if (last_g[1]) order.push_back(1);
            else if (last_g[0]) order.push_back(0);
            if (last_g[1]) begin
                k++;
                if (k < 12) drive(1, 1'b1, 1'b1, 32'(32'h40 + 4 * k), 32'(32'h1000 + k), k < 11);
                else drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
            end
        end
        chk("burst_beats", k, 12);
        for (int i = 0; i < 10 && i < order.size(); i++) chk("burst_order", order[i], (i == 8) ? 0 : 1);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();

        // Misaligned and out-of-range writes.
        r0 = ram[0];
        we_seen = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h102, 32'hCAFEF00D, 1'b0);
        tick();
        chk("err1_rerr", m0_if.rerr, 1'b1);
        chk("err1_rdata", m0_if.rdata, 32'd0);
        drive(0, 1'b1, 1'b1, 32'h100, 32'hCAFEF00D, 1'b0);
        tick();
        chk("err2_rerr", m0_if.rerr, 1'b1);
        chk("err2_rdata", m0_if.rdata, 32'd0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("err_we_seen", we_seen, 1'b0);
        chk("err_ram0", ram[0], r0);

        // Reset in the middle of an m1 burst, then same-word write/read race.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 1'b1, 32'(32'h80 + 4 * i), 32'(32'h2000 + i), 1'b1);
            tick();
            chk("lk_g1", last_g[1], 1'b1);
        end
        reset_n = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h20, 32'h1, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
        tick();
        chk("rstb_g0", last_g[0], 1'b0);
        chk("rstb_g1", last_g[1], 1'b0);
        chk("rstb_rv1", last_rv[1], 1'b0);
        reset_n = 1'b1;
        tick();
        chk("race_g0_first", last_g[0], 1'b1);
        chk("race_g1_wait", last_g[1], 1'b0);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("race_g1", last_g[1], 1'b1);
        chk("race_rdata", m1_if.rdata, 32'h1);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (acc[p]) pend[p] = 1'b0;
                if (!pend[p] && $urandom_range(3) != 0) begin
                    sel = $urandom_range(15);
                    if (sel == 0) nb.addr = {24'd0, 6'($urandom_range(63)), 2'($urandom_range(1, 3))};
                    else if (sel == 1) nb.addr = 32'(256 + 4 * $urandom_range(100));
                    else nb.addr = 32'(4 * $urandom_range(63));
                    nb.we    = 1'($urandom_range(1));
                    nb.lock  = 1'($urandom_range(1));
                    nb.wdata = $urandom;
                    pend[p]  = 1'b1;
                    drive(p, 1'b1, nb.we, nb.addr, nb.wdata, nb.lock);
                end else if (!pend[p]) begin
                    drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
                end
            end
            reset_n = ($urandom_range(99) != 0);
            tick();
        end
        reset_n = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        for (int i = 0; i < DEPTH; i++) chk("ram_final", ram[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
